// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory.
// Data has priority, but a fetch is forced in after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] ACK    = 2'd3;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    logic [1:0]    r_state;
    logic [SW-1:0] r_streak;

    logic w_grant_d;
    logic w_grant_i;

    // Data wins unless the fetch port has already waited out its allowance.
    assign w_grant_d = d_req && !(i_req && (r_streak == STREAK_MAX));
    assign w_grant_i = i_req && !w_grant_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            owner     <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        mem_req   <= 1'b1;
                        owner     <= 2'b10;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!i_req)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end else if (w_grant_i) begin
                        r_state   <= BUSY_I;
                        mem_req   <= 1'b1;
                        owner     <= 2'b01;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        r_streak  <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        r_state <= ACK;
                        mem_req <= 1'b0;
                        owner   <= 2'b00;
                        i_ack   <= 1'b1;
                        i_rdata <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        r_state <= ACK;
                        mem_req <= 1'b0;
                        owner   <= 2'b00;
                        d_ack   <= 1'b1;
                        d_rdata <= mem_rdata;
                    end
                end
                // One dead cycle so a request still held during its ack is not re-issued.
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 32, address width; DW, 32, data width; STARVE_MAX, 4, consecutive data grants allowed while the instruction port waits.
REQ-002 Port clock input 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset input 1: synchronous, active-high reset.
REQ-004 Port i_req input 1: instruction-fetch request (read only); held until i_ack.
REQ-005 Port i_addr input AW: fetch address; stable while i_req is high.
REQ-006 Port i_ack output 1: one-cycle completion pulse for the fetch port.
REQ-007 Port i_rdata output DW: fetched word; valid only in the i_ack cycle.
REQ-008 Port d_req input 1: data request; held until d_ack.
REQ-009 Port d_we input 1: data write enable (1 = store, 0 = load); stable while d_req is high.
REQ-010 Port d_addr input AW: data address; stable while d_req is high.
REQ-011 Port d_wdata input DW: store data; stable while d_req is high.
REQ-012 Port d_ack output 1: one-cycle completion pulse for the data port.
REQ-013 Port d_rdata output DW: load data; valid only in the d_ack cycle.
REQ-014 Port mem_req output 1: request to the single-ported memory.
REQ-015 Port mem_we output 1: memory write enable.
REQ-016 Port mem_addr output AW: memory address.
REQ-017 Port mem_wdata output DW: memory write data.
REQ-018 Port mem_rdata input DW: memory read data; valid when mem_ready is high.
REQ-019 Port mem_ready input 1: one-cycle memory completion; any latency of at least 1 cycle.
REQ-020 Port owner output 2: current memory owner (00 none, 01 fetch, 10 data).

Function
REQ-021 The FSM SHALL have exactly the states IDLE, BUSY_I, BUSY_D and ACK; all outputs SHALL be registered.
REQ-022 IDLE with neither request pending SHALL remain in IDLE.
REQ-023 IDLE with only d_req SHALL go to BUSY_D; with only i_req it SHALL go to BUSY_I.
REQ-024 IDLE with both requests SHALL go to BUSY_D unless streak == STARVE_MAX, in which case it SHALL go to BUSY_I.
REQ-025 The streak counter SHALL increment, saturating at STARVE_MAX, on each data grant made while i_req is high.
REQ-026 The streak counter SHALL clear on every fetch grant and on every data grant made while i_req is low.
REQ-027 On a grant, the next cycle SHALL drive mem_req=1 and owner to the grantee.
REQ-028 In the same cycle, mem_addr/mem_we/mem_wdata SHALL take the grantee's latched request; for the fetch port mem_we=0 and mem_wdata=0.
REQ-029 In BUSY_x these outputs SHALL hold constant until mem_ready is sampled high.
REQ-030 A mem_ready sampled high in BUSY_x SHALL move the FSM to ACK.
REQ-031 In ACK the matching ack SHALL be 1 for exactly one cycle, with the matching rdata equal to the captured mem_rdata (d_rdata captured for stores as well).
REQ-032 In ACK, mem_req SHALL be 0 and owner SHALL be 00.
REQ-033 ACK SHALL always go to IDLE and SHALL never grant, so a request still high in the ack cycle is not re-issued.
REQ-034 Timing: with a request at cycle N in IDLE and mem_ready at cycle M, mem_req SHALL be high in cycles N+1..M, ack SHALL pulse in M+1, and the next grant SHALL be decided in M+2 at the earliest.
REQ-035 mem_ready sampled outside BUSY_x SHALL be ignored.
REQ-036 Each rdata output SHALL hold its last value outside its ack cycle.
REQ-037 Requests arriving while not in IDLE SHALL wait and SHALL never be dropped.
REQ-038 i_ack and d_ack SHALL never be high in the same cycle.
REQ-039 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-040 Reset high at a rising edge SHALL force: state IDLE, streak 0, owner 00, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, i_ack 0, d_ack 0, i_rdata 0, d_rdata 0.
REQ-041 Reset SHALL take priority over every other condition.
REQ-042 Reset asserted mid-transaction SHALL abandon that transaction with no ack; a mem_ready arriving after reset SHALL be ignored.

Verification
REQ-043 Fetch only: i_req=1, i_addr=0x40, mem_ready 3 cycles after mem_req rises, mem_rdata=0x8C010004 -> mem_req high for 3 cycles with mem_addr=0x40 and mem_we=0; one-cycle i_ack with i_rdata=0x8C010004.
REQ-044 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ready after 1 cycle -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, d_ack one cycle; no i_ack.
REQ-045 Simultaneous i_req and d_req in the same IDLE cycle -> data served first; fetch served after the data ACK cycle.
REQ-046 Starvation: i_req held high while d_req is re-asserted immediately after every ack, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then streak returns to 0.
REQ-047 Reset pulse during BUSY_D, followed by mem_ready=1 -> all outputs at reset values, no d_ack, FSM stays in IDLE.
REQ-048 Requester keeps req high during the ack cycle -> no second mem_req issued before cycle M+2.
